// File: rtl/cache_victim_tracker.sv
// rtl/cache_victim_tracker.sv - per-set valid bits and true-LRU ages, one-hot victim query
// Holds replacement state for all sets and answers registered victim queries.
module cache_victim_tracker #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 8,
  localparam int SET_W = $clog2(SET_NUM),
  localparam int AGE_W = $clog2(WAY_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               touch_valid,
  input  logic [SET_W-1:0]   touch_set,
  input  logic [WAY_NUM-1:0] touch_way,
  input  logic               inval_valid,
  input  logic [SET_W-1:0]   inval_set,
  input  logic [WAY_NUM-1:0] inval_way,
  input  logic               flush,
  input  logic               vq_valid,
  output logic               vq_ready,
  input  logic [SET_W-1:0]   vq_set,
  output logic               vr_valid,
  input  logic               vr_ready,
  output logic [WAY_NUM-1:0] vr_way,
  output logic               vr_was_valid
);

  localparam logic [AGE_W-1:0] LRU_AGE = AGE_W'(WAY_NUM - 1);

  logic [WAY_NUM-1:0] valid_q [SET_NUM];
  logic [WAY_NUM-1:0] valid_d [SET_NUM];
  logic [AGE_W-1:0]   age_q   [SET_NUM][WAY_NUM];

  logic [WAY_NUM-1:0] inv_mask;
  logic [WAY_NUM-1:0] prio_way;
  logic [WAY_NUM-1:0] lru_way;
  logic [WAY_NUM-1:0] victim_way;
  logic [AGE_W-1:0]   touch_age;
  logic               vq_fire;

  assign vq_ready = ~vr_valid | vr_ready;
  assign vq_fire  = vq_valid & vq_ready;

  // Victim is taken from the state as it stands before this edge's updates.
  always_comb begin
    inv_mask  = ~valid_q[vq_set];
    prio_way  = '0;
    lru_way   = '0;
    touch_age = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (inv_mask[i]) begin
        prio_way    = '0;
        prio_way[i] = 1'b1;
      end
    end
    for (int i = 0; i < WAY_NUM; i++) begin
      lru_way[i] = (age_q[vq_set][i] == LRU_AGE);
      if (touch_way[i]) touch_age = touch_age | age_q[touch_set][i];
    end
    victim_way = (|inv_mask) ? prio_way : lru_way;
  end

  // Clearing before setting lets a touch win over an invalidate of the same way.
  always_comb begin
    for (int s = 0; s < SET_NUM; s++) begin
      valid_d[s] = valid_q[s];
      if (inval_valid && (inval_set == SET_W'(s))) valid_d[s] = valid_d[s] & ~inval_way;
      if (touch_valid && (touch_set == SET_W'(s))) valid_d[s] = valid_d[s] | touch_way;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        for (int i = 0; i < WAY_NUM; i++) age_q[s][i] <= AGE_W'(i);
      end
    end else if (flush) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        for (int i = 0; i < WAY_NUM; i++) age_q[s][i] <= AGE_W'(i);
      end
    end else begin
      for (int s = 0; s < SET_NUM; s++) valid_q[s] <= valid_d[s];
      if (touch_valid) begin
        for (int i = 0; i < WAY_NUM; i++) begin
          if (touch_way[i]) begin
            age_q[touch_set][i] <= '0;
          end else if (age_q[touch_set][i] < touch_age) begin
            age_q[touch_set][i] <= age_q[touch_set][i] + AGE_W'(1);
          end
        end
      end
    end
  end

  // One-entry response register; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vr_valid     <= 1'b0;
      vr_way       <= '0;
      vr_was_valid <= 1'b0;
    end else if (vq_fire) begin
      vr_valid     <= 1'b1;
      vr_way       <= victim_way;
      vr_was_valid <= ~(|inv_mask);
    end else if (vr_ready) begin
      vr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_victim_tracker.sv
// tb/tb_cache_victim_tracker.sv - directed scoreboard bench for cache_victim_tracker
// Expected responses are queued at query acceptance and compared when consumed.
module tb_cache_victim_tracker;

  localparam int WAY_NUM = 4;
  localparam int SET_NUM = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       touch_valid = 1'b0;
  logic [2:0] touch_set = '0;
  logic [3:0] touch_way = '0;
  logic       inval_valid = 1'b0;
  logic [2:0] inval_set = '0;
  logic [3:0] inval_way = '0;
  logic       flush = 1'b0;
  logic       vq_valid = 1'b0;
  logic       vq_ready;
  logic [2:0] vq_set = '0;
  logic       vr_valid;
  logic       vr_ready = 1'b1;
  logic [3:0] vr_way;
  logic       vr_was_valid;

  typedef struct packed {
    logic [3:0] way;
    logic       wv;
  } resp_t;

  resp_t sb[$];
  resp_t q_exp;
  string step = "init";
  int    n_checks = 0;
  int    n_pass = 0;

  cache_victim_tracker #(.WAY_NUM(WAY_NUM), .SET_NUM(SET_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
    .inval_valid(inval_valid), .inval_set(inval_set), .inval_way(inval_way),
    .flush(flush),
    .vq_valid(vq_valid), .vq_ready(vq_ready), .vq_set(vq_set),
    .vr_valid(vr_valid), .vr_ready(vr_ready), .vr_way(vr_way), .vr_was_valid(vr_was_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed %0h required %0h", step, tag, obs, exp);
  endtask

  // Consumed responses are popped first, then an accepted query pushes its expectation.
  task automatic cycle();
    resp_t e;
    @(negedge clk);
    if (vr_valid && vr_ready) begin
      chk("resp_onehot", 32'($onehot(vr_way)), 1);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("resp_way", 32'(vr_way), 32'(e.way));
        chk("resp_was_valid", 32'(vr_was_valid), 32'(e.wv));
      end
    end
    if (vq_valid && vq_ready && rst_n) sb.push_back(q_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input int s, input int w);
    touch_valid = 1'b1;
    touch_set   = 3'(s);
    touch_way   = 4'(1 << w);
    chk("touch_onehot", 32'($onehot(touch_way)), 1);
    cycle();
    touch_valid = 1'b0;
  endtask

  task automatic query(input int s, input logic [3:0] way, input logic wv);
    vq_valid = 1'b1;
    vq_set   = 3'(s);
    q_exp    = {way, wv};
    cycle();
    vq_valid = 1'b0;
    cycle();
  endtask

  task automatic perm_check();
    logic [3:0] m;
    for (int s = 0; s < SET_NUM; s++) begin
      m = '0;
      for (int i = 0; i < WAY_NUM; i++) m[dut.age_q[s][i]] = 1'b1;
      chk("age_perm", 32'(m), 32'hF);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    step = "reset";
    chk("vr_valid", 32'(vr_valid), 0);
    chk("vr_way", 32'(vr_way), 0);
    chk("vr_was_valid", 32'(vr_was_valid), 0);
    chk("vq_ready", 32'(vq_ready), 1);
    rst_n = 1'b1;
    cycle();

    step = "t1";
    vq_valid = 1'b1; vq_set = 3'd3; q_exp = {4'b0001, 1'b0};
    cycle();
    vq_valid = 1'b0;
    chk("latency_valid", 32'(vr_valid), 1);
    cycle();
    chk("drained", 32'(vr_valid), 0);
    perm_check();

    step = "t2";
    for (int w = 0; w < 4; w++) touch(3, w);
    query(3, 4'b0001, 1'b1);

    step = "t3";
    touch(3, 0);
    query(3, 4'b0010, 1'b1);
    inval_valid = 1'b1; inval_set = 3'd3; inval_way = 4'b0100;
    cycle();
    inval_valid = 1'b0;
    query(3, 4'b0100, 1'b0);
    perm_check();

    step = "t4";
    vr_ready = 1'b0;
    vq_valid = 1'b1; vq_set = 3'd3; q_exp = {4'b0100, 1'b0};
    cycle();
    vq_set = 3'd5; q_exp = {4'b0001, 1'b0};
    for (int k = 0; k < 5; k++) begin
      chk("stall_vq_ready", 32'(vq_ready), 0);
      chk("stall_vr_valid", 32'(vr_valid), 1);
      chk("stall_vr_way", 32'(vr_way), 32'b0100);
      cycle();
    end
    vr_ready = 1'b1;
    cycle();
    vq_set = 3'd3; q_exp = {4'b0100, 1'b0};
    chk("b2b_no_bubble", 32'(vr_valid), 1);
    cycle();
    vq_valid = 1'b0;
    chk("b2b_no_bubble2", 32'(vr_valid), 1);
    cycle();
    chk("b2b_drained", 32'(vr_valid), 0);
    chk("b2b_way_hold", 32'(vr_way), 32'b0100);

    step = "t5";
    touch_valid = 1'b1; touch_set = 3'd6; touch_way = 4'b0010;
    vq_valid = 1'b1; vq_set = 3'd6; q_exp = {4'b0001, 1'b0};
    cycle();
    touch_valid = 1'b0; vq_valid = 1'b0;
    cycle();
    query(6, 4'b0001, 1'b0);

    step = "same_way";
    touch_valid = 1'b1; touch_set = 3'd1; touch_way = 4'b0001;
    inval_valid = 1'b1; inval_set = 3'd1; inval_way = 4'b0001;
    cycle();
    touch_valid = 1'b0; inval_valid = 1'b0;
    for (int w = 1; w < 4; w++) touch(1, w);
    query(1, 4'b0001, 1'b1);

    step = "diff_way";
    for (int w = 0; w < 4; w++) touch(4, w);
    touch_valid = 1'b1; touch_set = 3'd4; touch_way = 4'b0001;
    inval_valid = 1'b1; inval_set = 3'd4; inval_way = 4'b0100;
    cycle();
    touch_valid = 1'b0; inval_valid = 1'b0;
    query(4, 4'b0100, 1'b0);
    perm_check();

    step = "t6_flush";
    vr_ready = 1'b0;
    vq_valid = 1'b1; vq_set = 3'd3; q_exp = {4'b0100, 1'b0};
    cycle();
    vq_valid = 1'b0;
    flush = 1'b1;
    touch_valid = 1'b1; touch_set = 3'd3; touch_way = 4'b0001;
    cycle();
    flush = 1'b0; touch_valid = 1'b0;
    chk("flush_vr_valid", 32'(vr_valid), 1);
    chk("flush_vr_way", 32'(vr_way), 32'b0100);
    chk("flush_vr_was_valid", 32'(vr_was_valid), 0);
    for (int i = 0; i < WAY_NUM; i++) chk("flush_age", 32'(dut.age_q[3][i]), 32'(i));
    perm_check();
    vr_ready = 1'b1;
    cycle();
    query(3, 4'b0001, 1'b0);
    query(6, 4'b0001, 1'b0);

    step = "t6_reset";
    for (int w = 0; w < 4; w++) touch(2, w);
    vr_ready = 1'b0;
    vq_valid = 1'b1; vq_set = 3'd2; q_exp = {4'b0001, 1'b1};
    cycle();
    vq_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vr_valid", 32'(vr_valid), 0);
    chk("rst_vr_way", 32'(vr_way), 0);
    chk("rst_vr_was_valid", 32'(vr_was_valid), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    vr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_idle", 32'(vr_valid), 0);
      cycle();
    end
    query(2, 4'b0001, 1'b0);
    query(5, 4'b0001, 1'b0);
    query(3, 4'b0001, 1'b0);
    perm_check();

    step = "end";
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
